// File: rtl/shift_seq_cmd_if.sv
// Command channel of the shift-register sequencer: valid/ready handshake
// carrying the operation, load/fill word and step count.
interface shift_seq_cmd_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [N-1:0]  cmd_data;
  logic [CW-1:0] cmd_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a universal shift register: turns load/shift/rotate commands
// into per-cycle ctrl/d drive and signals completion with a one-cycle done.
module shift_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_seq_cmd_if.slave       cmd,
  input  logic [N-1:0]         q_in,
  output logic [1:0]           ctrl,
  output logic [N-1:0]         d,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LEFT  = 2'b01;
  localparam logic [1:0] CTRL_RIGHT = 2'b10;
  localparam logic [1:0] CTRL_LOAD  = 2'b11;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          accept_s;

  assign accept_s = cmd.cmd_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  // A command is captured whole on accept; later cmd_* activity is ignored.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d   = cmd.cmd_op;
          data_d = cmd.cmd_data;
          rem_d  = cmd.cmd_cnt;
          if (cmd.cmd_op == OP_LOAD) begin
            state_d = LOAD;
          end else if (cmd.cmd_cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = DONE;
      end
      SHIFT: begin
        rem_d = rem_q - {{(CW-1){1'b0}}, 1'b1};
        if (rem_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        rem_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Outputs are a pure decode of the state registers; only the rotate feedback
  // bit passes combinationally from q_in to d.
  always_comb begin
    ctrl          = CTRL_HOLD;
    d             = '0;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    cmd.cmd_ready = (state_q == IDLE);
    case (state_q)
      LOAD: begin
        ctrl = CTRL_LOAD;
        d    = data_q;
      end
      SHIFT: begin
        case (op_q)
          OP_SHL: begin
            ctrl = CTRL_LEFT;
            d[0] = data_q[0];
          end
          OP_SHR: begin
            ctrl   = CTRL_RIGHT;
            d[N-1] = data_q[N-1];
          end
          OP_ROL: begin
            ctrl = CTRL_LEFT;
            d[0] = q_in[N-1];
          end
          default: begin
            ctrl = CTRL_HOLD;
            d    = '0;
          end
        endcase
      end
      default: begin
        ctrl = CTRL_HOLD;
        d    = '0;
      end
    endcase
  end

endmodule
